// File: rtl/dev_uart_rx_param_if.sv
// Receiver-side signal bundle for dev_uart_rx_param: baud tick and pad input in, received word out.
// The master modport is the receiver. The slave modport is the pad/tick source and byte consumer.
interface dev_uart_rx_param_if #(
    parameter int unsigned DATA_W = 8
);
    logic              TIC;
    logic              RxD;
    logic [DATA_W-1:0] RxQ;
    logic              RxSTB;
    logic              FERR;
    logic              PERR;
    logic              BRK;

    modport master (
        input  TIC,
        input  RxD,
        output RxQ,
        output RxSTB,
        output FERR,
        output PERR,
        output BRK
    );

    modport slave (
        output TIC,
        output RxD,
        input  RxQ,
        input  RxSTB,
        input  FERR,
        input  PERR,
        input  BRK
    );
endinterface

// File: rtl/dev_uart_rx_param.sv
// Parametrised oversampling UART receiver with start-glitch rejection, framing-error and break flags.
// Optional parity check is enabled by defining DEV_UART_RX_PARITY_EN.
module dev_uart_rx_param #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned OVS         = 8,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    dev_uart_rx_param_if.master    rx
);
    localparam int unsigned CW = $clog2(OVS);
    localparam int unsigned BW = $clog2(DATA_W);

    localparam logic [CW-1:0] HalfTic  = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] LastTic  = CW'(OVS - 1);
    localparam logic [BW-1:0] LastBit  = BW'(DATA_W - 1);
    localparam logic          LastStop = 1'(STOP_BITS - 1);

    if (DATA_W < 5 || DATA_W > 9 || OVS < 4 || (OVS % 2) != 0 || STOP_BITS < 1 ||
        STOP_BITS > 2 || SYNC_STAGES < 2 || PARITY_ODD > 1) begin : g_bad_param
        $error("dev_uart_rx_param: parameter out of range");
    end

`ifdef DEV_UART_RX_PARITY_EN
    typedef enum logic [2:0] {StHunt, StIdle, StStart, StData, StParity, StStop} state_e;
    localparam logic ParOdd = (PARITY_ODD != 0);
    logic par_bit;
`else
    typedef enum logic [2:0] {StHunt, StIdle, StStart, StData, StStop} state_e;
`endif

    state_e            state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_inc;
    logic [BW-1:0]     bit_cnt;
    logic              stop_cnt;
    logic              stop0_bad;
    logic [DATA_W-1:0] shift;
    logic [SYNC_STAGES-1:0] sync;
    logic              rxd_s;
    logic              first_stop_bad;
    logic              ferr_now;

    assign rxd_s   = sync[SYNC_STAGES-1];
    assign cnt_inc = (cnt == LastTic) ? '0 : cnt + 1'b1;

    // With two stop bits the first one was captured earlier; with one, it is the current sample.
    assign first_stop_bad = (stop_cnt == 1'b0) ? ~rxd_s : stop0_bad;
    assign ferr_now       = ~rxd_s | ((stop_cnt != 1'b0) & stop0_bad);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx.RxD};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= StHunt;
            cnt       <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            stop0_bad <= 1'b0;
            shift     <= '0;
`ifdef DEV_UART_RX_PARITY_EN
            par_bit   <= 1'b0;
`endif
            rx.RxQ    <= '0;
            rx.RxSTB  <= 1'b0;
            rx.FERR   <= 1'b0;
            rx.PERR   <= 1'b0;
            rx.BRK    <= 1'b0;
        end else begin
            rx.RxSTB <= 1'b0;
            if (rx.TIC) begin
                case (state)
                    StHunt: begin
                        if (rxd_s) state <= StIdle;
                    end
                    StIdle: begin
                        if (!rxd_s) begin
                            state <= StStart;
                            cnt   <= '0;
                        end
                    end
                    StStart: begin
                        if (cnt == HalfTic) begin
                            cnt     <= '0;
                            bit_cnt <= '0;
                            state   <= rxd_s ? StIdle : StData;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    StData: begin
                        cnt <= cnt_inc;
                        if (cnt == LastTic) begin
                            shift <= {rxd_s, shift[DATA_W-1:1]};
                            if (bit_cnt == LastBit) begin
                                stop_cnt <= 1'b0;
`ifdef DEV_UART_RX_PARITY_EN
                                state    <= StParity;
`else
                                state    <= StStop;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
`ifdef DEV_UART_RX_PARITY_EN
                    StParity: begin
                        cnt <= cnt_inc;
                        if (cnt == LastTic) begin
                            par_bit <= rxd_s;
                            state   <= StStop;
                        end
                    end
`endif
                    StStop: begin
                        cnt <= cnt_inc;
                        if (cnt == LastTic) begin
                            if (stop_cnt == LastStop) begin
                                rx.RxQ   <= shift;
                                rx.RxSTB <= 1'b1;
                                rx.FERR  <= ferr_now;
                                rx.BRK   <= (shift == '0) & first_stop_bad;
`ifdef DEV_UART_RX_PARITY_EN
                                rx.PERR  <= (^shift) ^ par_bit ^ ParOdd;
`else
                                rx.PERR  <= 1'b0;
`endif
                                // A bad stop waits for the line to idle high again.
                                state    <= ferr_now ? StHunt : StIdle;
                            end else begin
                                stop0_bad <= ~rxd_s;
                                stop_cnt  <= stop_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= StHunt;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dev_uart_rx_param.sv
// Scoreboard bench for dev_uart_rx_param (DATA_W=8, OVS=8, STOP_BITS=1).
module tb_dev_uart_rx_param;
    localparam int DATA_W = 8;
    localparam int OVS    = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    dev_uart_rx_param_if #(.DATA_W(DATA_W)) rx_if ();

    dev_uart_rx_param #(
        .DATA_W      (DATA_W),
        .OVS         (OVS),
        .STOP_BITS   (1),
        .SYNC_STAGES (3),
        .PARITY_ODD  (0)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .rx  (rx_if)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] q;
        logic       ferr;
        logic       perr;
        logic       brk;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   tic_div    = 4;
    int   tic_c      = 0;
    logic prev_stb   = 1'b0;

    // TIC source, changed on the falling edge so it is stable at the DUT's sampling edge.
    initial begin
        rx_if.TIC = 1'b0;
        forever begin
            @(negedge CLK);
            if (tic_div <= 1) begin
                rx_if.TIC = 1'b1;
                tic_c     = 0;
            end else begin
                rx_if.TIC = (tic_c == 0);
                tic_c     = (tic_c + 1) % tic_div;
            end
        end
    end

    // Monitor: every strobe pops one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (rx_if.RxSTB) begin
                vectors++;
                if (prev_stb) begin
                    miscompares++;
                    $display("FAIL stb_width: RxSTB high for 2+ cycles, required 1");
                end else if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_stb: got RxQ=%02h FERR=%0b BRK=%0b, required no strobe",
                             rx_if.RxQ, rx_if.FERR, rx_if.BRK);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_if.RxQ !== e.q || rx_if.FERR !== e.ferr || rx_if.PERR !== e.perr ||
                        rx_if.BRK !== e.brk) begin
                        miscompares++;
                        $display("FAIL frame: got RxQ=%02h FERR=%0b PERR=%0b BRK=%0b, required RxQ=%02h FERR=%0b PERR=%0b BRK=%0b",
                                 rx_if.RxQ, rx_if.FERR, rx_if.PERR, rx_if.BRK,
                                 e.q, e.ferr, e.perr, e.brk);
                    end
                end
            end
            prev_stb = rx_if.RxSTB;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    function automatic int bit_clks();
        return OVS * tic_div;
    endfunction

    task automatic hold(input logic b, input int clks);
        rx_if.RxD = b;
        repeat (clks) @(negedge CLK);
    endtask

    task automatic push(input logic [7:0] q, input logic ferr, input logic perr, input logic brk);
        exp_t e;
        e.q = q; e.ferr = ferr; e.perr = perr; e.brk = brk;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        hold(1'b0, bit_clks());
        for (int i = 0; i < 8; i++) hold(d[i], bit_clks());
`ifdef DEV_UART_RX_PARITY_EN
        hold(par, bit_clks());
`else
        if (par === 1'bx) hold(1'b1, 0);
`endif
        hold(stop, bit_clks());
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge CLK);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d expected strobes missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset(input string name);
        vectors++;
        if (rx_if.RxQ !== 8'h00 || rx_if.RxSTB !== 1'b0 || rx_if.FERR !== 1'b0 ||
            rx_if.PERR !== 1'b0 || rx_if.BRK !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got RxQ=%02h STB=%0b FERR=%0b PERR=%0b BRK=%0b, required all 0",
                     name, rx_if.RxQ, rx_if.RxSTB, rx_if.FERR, rx_if.PERR, rx_if.BRK);
        end
    endtask

    task automatic reset_mid_frame(input string name);
        logic [7:0] d;
        d = 8'hC6;
        hold(1'b0, bit_clks());
        for (int i = 0; i < 4; i++) hold(d[i], bit_clks());
        hold(d[4], bit_clks() / 2);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_reset(name);
        hold(1'b1, 3 * bit_clks());
        push(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        hold(1'b1, bit_clks());
        drain({name, "_5a"});
    endtask

    initial begin
        rx_if.RxD = 1'b1;
        RST       = 1'b1;
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        check_reset("reset");
        hold(1'b1, 2 * bit_clks());

        // Back-to-back frames
        push(8'h55, 1'b0, 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, ^8'h55);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        hold(1'b1, bit_clks());
        drain("b2b");

        // Start glitch of two ticks, then a real frame
        hold(1'b0, 2 * tic_div);
        hold(1'b1, 2 * bit_clks());
        push(8'hA3, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b1, ^8'hA3);
        hold(1'b1, bit_clks());
        drain("glitch_a3");

        // Framing error, then recovery
        push(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, ^8'h3C);
        hold(1'b1, 2 * bit_clks());
        drain("ferr_3c");
        push(8'h12, 1'b0, 1'b0, 1'b0);
        send_frame(8'h12, 1'b1, ^8'h12);
        hold(1'b1, bit_clks());
        drain("after_ferr_12");

        // Break: long low line gives exactly one strobe
        push(8'h00, 1'b1, 1'b0, 1'b1);
        hold(1'b0, 20 * bit_clks());
        hold(1'b1, 2 * bit_clks());
        drain("break");
        push(8'h81, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, ^8'h81);
        hold(1'b1, bit_clks());
        drain("after_brk_81");

        // Parity
`ifdef DEV_UART_RX_PARITY_EN
        push(8'h07, 1'b0, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        push(8'h07, 1'b0, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0);
`else
        push(8'h07, 1'b0, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
`endif
        hold(1'b1, bit_clks());
        drain("parity_07");

        // Reset during data bit 4, with divided TIC and then TIC tied high
        reset_mid_frame("rst_mid_tic4");
        tic_div = 1;
        hold(1'b1, 4);
        reset_mid_frame("rst_mid_tic1");

        hold(1'b1, 100);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL final_queue: %0d left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
